// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook timer: FSM state encoding,
// BCD digit sizing and a counter-width helper.
package microwave_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX       = 4'd9;
  localparam bcd_t SEC_TENS_WRAP = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COOK   = 3'd1,
    ST_PAUSED = 3'd2,
    ST_DONE   = 3'd3
  } state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_countdown4.sv
// Four-digit MM:SS BCD register with keypad shift-in, one-second decrement and clear.
// Flags report an all-zero value and a decrement that would land on zero.
module bcd_countdown4
  import microwave_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic shift_i,
  input  bcd_t digit_i,
  input  logic dec_i,
  output bcd_t min_tens_o,
  output bcd_t min_ones_o,
  output bcd_t sec_tens_o,
  output bcd_t sec_ones_o,
  output logic zero_o,
  output logic dec_to_zero_o
);

  // Index 3 = minute tens ... index 0 = second ones.
  bcd_t [3:0] dig_q, dig_d;

  always_comb begin
    // NOTE: default every output of an always_comb first so no path infers a latch.
    dig_d = dig_q;
    if (clear_i) begin
      dig_d = '0;
    end else if (shift_i) begin
      dig_d = {dig_q[2], dig_q[1], dig_q[0], digit_i};
    end else if (dec_i && !zero_o) begin
      // Seconds-tens borrows to 5, but keyed values above 5 simply count down.
      if (dig_q[0] != 4'd0) begin
        dig_d[0] = dig_q[0] - 4'd1;
      end else begin
        dig_d[0] = BCD_MAX;
        if (dig_q[1] != 4'd0) begin
          dig_d[1] = dig_q[1] - 4'd1;
        end else begin
          dig_d[1] = SEC_TENS_WRAP;
          if (dig_q[2] != 4'd0) begin
            dig_d[2] = dig_q[2] - 4'd1;
          end else begin
            dig_d[2] = BCD_MAX;
            dig_d[3] = dig_q[3] - 4'd1;
          end
        end
      end
    end
  end

  // NOTE: the digit register is small state, not a memory, so it takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
    end else begin
      // NOTE: non-blocking assignment for all clocked state avoids read/write races.
      dig_q <= dig_d;
    end
  end

  assign zero_o        = (dig_q == 16'h0000);
  assign dec_to_zero_o = (dig_q == 16'h0001);

  assign min_tens_o = dig_q[3];
  assign min_ones_o = dig_q[2];
  assign sec_tens_o = dig_q[1];
  assign sec_ones_o = dig_q[0];

endmodule

// File: rtl/microwave_cook_timer.sv
// Cook-time countdown and magnetron control: tick prescaler, beep timer and the
// IDLE/COOK/PAUSED/DONE sequencer driving the BCD countdown register.
module microwave_cook_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 100,
  parameter int DONE_BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       beep,
  output logic       done,
  output logic [2:0] state
);

  localparam int PRESC_W    = cnt_width(TICKS_PER_SEC);
  localparam int BEEP_TICKS = DONE_BEEP_SECS * TICKS_PER_SEC;
  localparam int BEEP_W     = cnt_width(BEEP_TICKS);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LAST  = BEEP_W'(BEEP_TICKS - 1);

  state_e              state_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [BEEP_W-1:0]   beep_cnt_q;
  logic                done_q;

  logic time_zero, dec_to_zero;
  logic sec_tick, start_ok, cnt_dec, cnt_shift;

  // A second boundary is a tick arriving with the prescaler at its last count.
  assign sec_tick  = tick && (presc_q == PRESC_LAST);
  assign start_ok  = start && !door_open && !pause && !time_zero;
  // Reaching zero outranks door/pause; an ordinary decrement does not.
  assign cnt_dec   = !cancel && (state_q == ST_COOK) && sec_tick &&
                     (dec_to_zero || !(door_open || pause));
  assign cnt_shift = !cancel && (state_q == ST_IDLE) && !start_ok &&
                     digit_valid && (digit <= BCD_MAX);

  bcd_countdown4 u_count (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (cancel),
    .shift_i      (cnt_shift),
    .digit_i      (digit),
    .dec_i        (cnt_dec),
    .min_tens_o   (min_tens),
    .min_ones_o   (min_ones),
    .sec_tens_o   (sec_tens),
    .sec_ones_o   (sec_ones),
    .zero_o       (time_zero),
    .dec_to_zero_o(dec_to_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      beep_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cancel) begin
        state_q    <= ST_IDLE;
        presc_q    <= '0;
        beep_cnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_ok) begin
              state_q <= ST_COOK;
              presc_q <= '0;
            end
          end
          ST_COOK: begin
            if (sec_tick && dec_to_zero) begin
              state_q    <= ST_DONE;
              presc_q    <= '0;
              beep_cnt_q <= '0;
              done_q     <= 1'b1;
            end else if (door_open || pause) begin
              state_q <= ST_PAUSED;
            end else if (tick) begin
              presc_q <= sec_tick ? '0 : presc_q + 1'b1;
            end
          end
          ST_PAUSED: begin
            if (start && !door_open && !pause) begin
              state_q <= ST_COOK;
            end
          end
          ST_DONE: begin
            if (tick) begin
              if (beep_cnt_q == BEEP_LAST) begin
                state_q    <= ST_IDLE;
                beep_cnt_q <= '0;
              end else begin
                beep_cnt_q <= beep_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign magnetron_on = (state_q == ST_COOK);
  assign beep         = (state_q == ST_DONE);
  assign done         = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_microwave_cook_timer.sv
// Directed bench for microwave_cook_timer with TICKS_PER_SEC=4, DONE_BEEP_SECS=2.
module tb_microwave_cook_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, digit_valid = 1'b0, start = 1'b0;
  logic       pause = 1'b0, cancel = 1'b0, door_open = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       magnetron_on, beep, done;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_COOK = 3'd1, S_PAUSED = 3'd2, S_DONE = 3'd3;

  microwave_cook_timer #(.TICKS_PER_SEC(4), .DONE_BEEP_SECS(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .digit_valid(digit_valid), .digit(digit),
    .start(start), .pause(pause), .cancel(cancel), .door_open(door_open),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .magnetron_on(magnetron_on), .beep(beep), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  wire [15:0] disp = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit = d; digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic press_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  initial begin
    #12;
    check("reset_state", {13'd0, state}, 16'd0);
    check("reset_disp", disp, 16'h0000);
    check("reset_flags", {13'd0, magnetron_on, beep, done}, 16'd0);
    rst_n = 1'b1;
    step();

    // 1: 01:30 countdown through the minute borrow
    key(4'd1); key(4'd3); key(4'd0);
    check("t1_keyed", disp, 16'h0130);
    press_start();
    check("t1_cook", {15'd0, magnetron_on}, 16'd1);
    ticks(4);
    check("t1_0129", disp, 16'h0129);
    ticks(29 * 4);
    check("t1_0100", disp, 16'h0100);
    ticks(4);
    check("t1_0059", disp, 16'h0059);
    press_cancel();
    check("t1_cancel", disp, 16'h0000);

    // 2: 00:99 and out-of-range key
    key(4'd9); key(4'd9);
    check("t2_keyed", disp, 16'h0099);
    key(4'hA);
    check("t2_badkey", disp, 16'h0099);
    press_start();
    ticks(4);
    check("t2_0098", disp, 16'h0098);
    press_cancel();

    // 3: door pause mid-second, resume keeps prescaler
    key(4'd5);
    press_start();
    ticks(2);
    door_open = 1'b1;
    step();
    check("t3_paused", {13'd0, state}, {13'd0, S_PAUSED});
    check("t3_mag_off", {15'd0, magnetron_on}, 16'd0);
    ticks(4);
    check("t3_hold", disp, 16'h0005);
    press_start();
    check("t3_door_start", {13'd0, state}, {13'd0, S_PAUSED});
    door_open = 1'b0;
    press_start();
    check("t3_resume", {13'd0, state}, {13'd0, S_COOK});
    ticks(1);
    check("t3_one_tick", disp, 16'h0005);
    ticks(1);
    check("t3_0004", disp, 16'h0004);
    press_cancel();

    // 4: finish, done pulse, beep window
    key(4'd1);
    press_start();
    ticks(3);
    check("t4_still_cook", {13'd0, state}, {13'd0, S_COOK});
    ticks(1);
    check("t4_zero", disp, 16'h0000);
    check("t4_done_pulse", {13'd0, state, done}, {12'd0, S_DONE, 1'b1});
    step();
    check("t4_done_clear", {14'd0, done, beep}, 16'd1);
    ticks(7);
    check("t4_beep7", {15'd0, beep}, 16'd1);
    ticks(1);
    check("t4_idle", {13'd0, state}, {13'd0, S_IDLE});
    check("t4_beep_off", {15'd0, beep}, 16'd0);
    press_start();
    check("t4_start_zero", {13'd0, state}, {13'd0, S_IDLE});

    // 5: cancel beats start in PAUSED
    key(4'd2);
    press_start();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("t5_paused", {13'd0, state}, {13'd0, S_PAUSED});
    cancel = 1'b1; start = 1'b1;
    step();
    cancel = 1'b0; start = 1'b0;
    check("t5_idle", {13'd0, state}, {13'd0, S_IDLE});
    check("t5_disp", disp, 16'h0000);
    check("t5_mag", {15'd0, magnetron_on}, 16'd0);

    // 99:99 keyed maximum
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    check("max_entry", disp, 16'h9999);
    press_cancel();

    // 6: asynchronous reset between edges
    key(4'd3);
    press_start();
    ticks(1);
    check("t6_cook", {13'd0, state}, {13'd0, S_COOK});
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async", {state, magnetron_on, beep, done}, 6'd0);
    check("t6_disp", disp, 16'h0000);
    #5;
    rst_n = 1'b1;
    step();
    check("t6_after", {13'd0, state}, {13'd0, S_IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
